mem_ctrl: RTL and testbench

Memory controller between the core and the byte-wide unified RAM/IO port. Serves two requesters: the load/store buffer (byte/half/word reads and writes) and the instruction fetcher (word reads). Multi-byte accesses are serialised one byte per cycle, little-endian. Each requester gets a one-cycle completion pulse with the assembled 32-bit data.

---
 rtl/mem_ctrl.sv | 271 +++++++++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl
// Summary  : Byte-serial memory controller. Arbitrates the load/store buffer
//            (byte/half/word reads and writes) and the instruction fetcher
//            (word reads) onto a byte-wide RAM/IO port, little-endian.
// Options  : MEMCTRL_IO_STALL_EN - when defined, write bytes aimed at IO space
//            (addr[17:16] == 2'b11) are held while io_buffer_full is high.
// Revision : 1.0 - initial release
// ============================================================================
module mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              enable_from_lsb,
  input  logic              read_or_write_from_lsb,
  input  logic [ADDR_W-1:0] addr_from_lsb,
  input  logic [31:0]       data_from_lsb,
  input  logic [2:0]        width_from_lsb,
  output logic              ok_to_lsb,
  output logic [31:0]       data_to_lsb,
  input  logic              enable_from_if,
  input  logic [ADDR_W-1:0] addr_from_if,
  output logic              ok_to_if,
  output logic [31:0]       inst_to_if,
  input  logic              mispredict,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    IF_READ  = 3'd1,
    LS_READ  = 3'd2,
    LS_WRITE = 3'd3,
    DONE     = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        width_q, width_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rbuf_q, rbuf_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic              mem_wr_q, mem_wr_d;
  logic [7:0]        mem_dout_q, mem_dout_d;
  logic              ok_lsb_q, ok_lsb_d;
  logic              ok_if_q, ok_if_d;
  logic [31:0]       data_lsb_q, data_lsb_d;
  logic [31:0]       inst_q, inst_d;

  // Skid capture of the RAM byte that is in flight when rdy drops.
  logic              frozen_q;
  logic [7:0]        skid_q;
  logic [7:0]        din_eff;

  // Write-byte selection shared by the accept cycle and the write state.
  logic [ADDR_W-1:0] wr_base;
  logic [1:0]        wr_idx;
  logic [31:0]       wr_src;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_byte;
  logic              wr_stall;

  logic [1:0]        rd_idx;
  logic [2:0]        rd_next;

  // Widths other than 1 or 2 bytes are serviced as full words.
  function automatic logic [2:0] decode_width(input logic [2:0] w);
    case (w)
      3'd1:    return 3'd1;
      3'd2:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Pick base/offset/data for the write byte to be issued at the next edge.
  always_comb begin
    if (state_q == LS_WRITE) begin
      wr_base = addr_q;
      wr_idx  = cnt_q[1:0];
      wr_src  = wdata_q;
    end else begin
      wr_base = addr_from_lsb;
      wr_idx  = 2'd0;
      wr_src  = data_from_lsb;
    end
  end

  assign wr_addr = wr_base + ADDR_W'(wr_idx);
  assign wr_byte = wr_src[{wr_idx, 3'b000} +: 8];

`ifdef MEMCTRL_IO_STALL_EN
  assign wr_stall = (wr_addr[17:16] == 2'b11) && io_buffer_full;
`else
  logic unused_io_buffer_full;
  assign unused_io_buffer_full = io_buffer_full;
  assign wr_stall = 1'b0;
`endif

  // Counter value c captures byte c-1; the next address issued is addr+c+1.
  assign rd_idx  = cnt_q[1:0] - 2'd1;
  assign rd_next = cnt_q + 3'd1;

  // While frozen the RAM keeps reading the held address, so the byte that was
  // on mem_din at the first frozen edge is replayed on the resuming edge.
  assign din_eff = frozen_q ? skid_q : mem_din;

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    width_d    = width_q;
    wdata_d    = wdata_q;
    rbuf_d     = rbuf_q;
    mem_a_d    = mem_a_q;
    mem_wr_d   = 1'b0;
    mem_dout_d = 8'h00;
    ok_lsb_d   = 1'b0;
    ok_if_d    = 1'b0;
    data_lsb_d = data_lsb_q;
    inst_d     = inst_q;

    case (state_q)
      IDLE: begin
        if (!mispredict) begin
          if (enable_from_lsb) begin
            addr_d  = addr_from_lsb;
            width_d = decode_width(width_from_lsb);
            rbuf_d  = 32'h0;
            cnt_d   = 3'd0;
            if (read_or_write_from_lsb) begin
              wdata_d = data_from_lsb;
              state_d = LS_WRITE;
              if (!wr_stall) begin
                mem_a_d    = wr_addr;
                mem_wr_d   = 1'b1;
                mem_dout_d = wr_byte;
                cnt_d      = 3'd1;
              end
            end else begin
              mem_a_d = addr_from_lsb;
              state_d = LS_READ;
            end
          end else if (enable_from_if) begin
            addr_d  = addr_from_if;
            width_d = 3'd4;
            rbuf_d  = 32'h0;
            cnt_d   = 3'd0;
            mem_a_d = addr_from_if;
            state_d = IF_READ;
          end
        end
      end

      IF_READ, LS_READ: begin
        if (mispredict) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end else begin
          if (cnt_q != 3'd0) begin
            rbuf_d[{rd_idx, 3'b000} +: 8] = din_eff;
          end
          if (cnt_q == width_q) begin
            state_d = DONE;
            cnt_d   = 3'd0;
            if (state_q == IF_READ) begin
              ok_if_d = 1'b1;
              inst_d  = rbuf_d;
            end else begin
              ok_lsb_d   = 1'b1;
              data_lsb_d = rbuf_d;
            end
          end else begin
            cnt_d = rd_next;
            if (rd_next < width_q) begin
              mem_a_d = addr_q + ADDR_W'(rd_next);
            end
          end
        end
      end

      LS_WRITE: begin
        if (cnt_q == width_q) begin
          ok_lsb_d = 1'b1;
          state_d  = DONE;
          cnt_d    = 3'd0;
        end else if (!wr_stall) begin
          mem_a_d    = wr_addr;
          mem_wr_d   = 1'b1;
          mem_dout_d = wr_byte;
          cnt_d      = cnt_q + 3'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // State and datapath registers; rdy low freezes everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      addr_q     <= '0;
      width_q    <= 3'd0;
      wdata_q    <= 32'h0;
      rbuf_q     <= 32'h0;
      mem_a_q    <= '0;
      mem_wr_q   <= 1'b0;
      mem_dout_q <= 8'h00;
      ok_lsb_q   <= 1'b0;
      ok_if_q    <= 1'b0;
      data_lsb_q <= 32'h0;
      inst_q     <= 32'h0;
    end else if (rdy) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      width_q    <= width_d;
      wdata_q    <= wdata_d;
      rbuf_q     <= rbuf_d;
      mem_a_q    <= mem_a_d;
      mem_wr_q   <= mem_wr_d;
      mem_dout_q <= mem_dout_d;
      ok_lsb_q   <= ok_lsb_d;
      ok_if_q    <= ok_if_d;
      data_lsb_q <= data_lsb_d;
      inst_q     <= inst_d;
    end
  end

  // Hold the first mem_din seen after rdy drops, release on resume.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frozen_q <= 1'b0;
      skid_q   <= 8'h00;
    end else if (!rdy) begin
      if (!frozen_q) begin
        frozen_q <= 1'b1;
        skid_q   <= mem_din;
      end
    end else begin
      frozen_q <= 1'b0;
    end
  end

  assign ok_to_lsb   = ok_lsb_q;
  assign ok_to_if    = ok_if_q;
  assign data_to_lsb = data_lsb_q;
  assign inst_to_if  = inst_q;
  assign mem_a       = mem_a_q;
  assign mem_wr      = mem_wr_q & rdy;
  assign mem_dout    = rdy ? mem_dout_q : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_ctrl
// Summary  : Scoreboard bench for mem_ctrl with a byte-wide synchronous RAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        enable_from_lsb = 1'b0;
  logic        read_or_write_from_lsb = 1'b0;
  logic [31:0] addr_from_lsb = 32'h0;
  logic [31:0] data_from_lsb = 32'h0;
  logic [2:0]  width_from_lsb = 3'd0;
  logic        ok_to_lsb;
  logic [31:0] data_to_lsb;
  logic        enable_from_if = 1'b0;
  logic [31:0] addr_from_if = 32'h0;
  logic        ok_to_if;
  logic [31:0] inst_to_if;
  logic        mispredict = 1'b0;
  logic [7:0]  mem_din = 8'h00;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full = 1'b0;

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .rdy                    (rdy),
    .enable_from_lsb        (enable_from_lsb),
    .read_or_write_from_lsb (read_or_write_from_lsb),
    .addr_from_lsb          (addr_from_lsb),
    .data_from_lsb          (data_from_lsb),
    .width_from_lsb         (width_from_lsb),
    .ok_to_lsb              (ok_to_lsb),
    .data_to_lsb            (data_to_lsb),
    .enable_from_if         (enable_from_if),
    .addr_from_if           (addr_from_if),
    .ok_to_if               (ok_to_if),
    .inst_to_if             (inst_to_if),
    .mispredict             (mispredict),
    .mem_din                (mem_din),
    .mem_dout               (mem_dout),
    .mem_a                  (mem_a),
    .mem_wr                 (mem_wr),
    .io_buffer_full         (io_buffer_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    bit          chk;
    int          cyc;
  } exp_t;

  exp_t q_lsb[$];
  exp_t q_if[$];
  int   tests  = 0;
  int   errors = 0;
  int   cyc    = 0;

  logic [7:0]  ram        [0:262143];
  logic [31:0] a_trace    [0:4095];
  logic        wr_trace   [0:4095];
  logic [7:0]  dout_trace [0:4095];

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM: data for the address of the previous cycle.
  always @(posedge clk) begin
    mem_din <= ram[mem_a[17:0]];
    if (mem_wr) ram[mem_a[17:0]] = mem_dout;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_ok(input string name, inout exp_t q[$], input logic [31:0] act);
    exp_t e;
    tests++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected pulse at cycle %0d data %h", name, cyc, act);
    end else begin
      e = q.pop_front();
      if ((e.chk && act !== e.data) || (e.cyc >= 0 && cyc != e.cyc)) begin
        errors++;
        $display("FAIL %s: got data %h cycle %0d expected data %h cycle %0d",
                 name, act, cyc, e.data, e.cyc);
      end
    end
  endtask

  // Monitor: record bus trace, score every completion pulse.
  always @(posedge clk) begin
    #1;
    if (cyc < 4096) begin
      a_trace[cyc]    = mem_a;
      wr_trace[cyc]   = mem_wr;
      dout_trace[cyc] = mem_dout;
    end
    if (ok_to_lsb) check_ok("ok_to_lsb", q_lsb, data_to_lsb);
    if (ok_to_if)  check_ok("ok_to_if",  q_if,  inst_to_if);
  end

  // LSB requester: called just after an edge; lat = edges until ok is seen.
  task automatic lsb_req(input logic rw, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] w, input logic [31:0] exp, input int lat,
                         output int acc);
    exp_t e;
    int   n;
    e.data = exp;
    e.chk  = !rw;
    e.cyc  = (lat < 0) ? -1 : cyc + lat;
    q_lsb.push_back(e);
    acc = cyc + 1;
    read_or_write_from_lsb = rw;
    addr_from_lsb = a;
    data_from_lsb = d;
    width_from_lsb = w;
    enable_from_lsb = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!ok_to_lsb && n < 60);
    if (!ok_to_lsb) begin
      tests++; errors++;
      $display("FAIL lsb_timeout: got no ok_to_lsb expected one for addr %h", a);
    end
    @(posedge clk); #1;
    enable_from_lsb = 1'b0;
  endtask

  task automatic if_req(input logic [31:0] a, input logic [31:0] exp, input int lat);
    exp_t e;
    int   n;
    e.data = exp;
    e.chk  = 1'b1;
    e.cyc  = (lat < 0) ? -1 : cyc + lat;
    q_if.push_back(e);
    addr_from_if = a;
    enable_from_if = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!ok_to_if && n < 60);
    if (!ok_to_if) begin
      tests++; errors++;
      $display("FAIL if_timeout: got no ok_to_if expected one for addr %h", a);
    end
    @(posedge clk); #1;
    enable_from_if = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    for (int i = 0; i < 262144; i++) ram[i] = 8'h00;
    ram[32'h100] = 8'h11; ram[32'h101] = 8'h22; ram[32'h102] = 8'h33; ram[32'h103] = 8'h44;
    ram[32'h104] = 8'h55; ram[32'h105] = 8'h66; ram[32'h106] = 8'h77; ram[32'h107] = 8'h88;
    ram[32'h201] = 8'h5A;
    ram[32'h10]  = 8'hCD; ram[32'h11]  = 8'hAB; ram[32'h12]  = 8'hFF;
    ram[32'h0]   = 8'h13; ram[32'h1]   = 8'h05;
    ram[32'h20]  = 8'h01; ram[32'h21]  = 8'h02; ram[32'h22]  = 8'h03; ram[32'h23]  = 8'h04;
    ram[32'h40]  = 8'h93; ram[32'h41]  = 8'h85; ram[32'h42]  = 8'hC5; ram[32'h43]  = 8'h00;
    ram[32'h3FFFF] = 8'h9A;
    ram[32'h502] = 8'h77;
    for (int i = 0; i < 4; i++) ram[32'h400 + i] = 8'hEE;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ok_lsb", 32'(ok_to_lsb), 32'h0);
    check("rst_ok_if", 32'(ok_to_if), 32'h0);
    check("rst_mem_wr", 32'(mem_wr), 32'h0);
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_mem_dout", 32'(mem_dout), 32'h0);
    check("rst_data_lsb", data_to_lsb, 32'h0);
    check("rst_inst", inst_to_if, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    // LW 0x100: ok six cycles after accept, address walk 0x100..0x103
    lsb_req(1'b0, 32'h100, 32'h0, 3'd4, 32'h44332211, 6, acc);
    for (int k = 0; k < 4; k++) check("lw_mem_a", a_trace[acc + k], 32'h100 + k);

    // Width 3 treated as a word
    lsb_req(1'b0, 32'h100, 32'h0, 3'd3, 32'h44332211, 6, acc);

    // SB 0xAB at 0x200
    lsb_req(1'b1, 32'h200, 32'h0000_00AB, 3'd1, 32'h0, 2, acc);
    check("sb_mem_a", a_trace[acc], 32'h200);
    check("sb_wr", 32'({wr_trace[acc], wr_trace[acc + 1], wr_trace[acc + 2]}), 32'b100);
    check("sb_dout", 32'(dout_trace[acc]), 32'hAB);
    check("sb_ram", 32'(ram[32'h200]), 32'hAB);
    check("sb_ram_next", 32'(ram[32'h201]), 32'h5A);

    // SH 0x1234 at 0x500
    lsb_req(1'b1, 32'h500, 32'hFFFF_1234, 3'd2, 32'h0, 3, acc);
    check("sh_ram", 32'({ram[32'h502], ram[32'h501], ram[32'h500]}), 32'h771234);

    // LH at 0xFFFFFFFF wraps to 0x0
    lsb_req(1'b0, 32'hFFFF_FFFF, 32'h0, 3'd2, 32'h0000_139A, 4, acc);
    check("wrap_mem_a", a_trace[acc + 1], 32'h0);

    // LSB priority: LH 0x10 and fetch 0x0 raised together
    fork
      lsb_req(1'b0, 32'h10, 32'h0, 3'd2, 32'h0000_ABCD, 4, acc);
      if_req(32'h0, 32'h0000_0513, 11);
    join

    // Fetch aborted by mispredict in cycle 3, then a fresh fetch
    addr_from_if = 32'h20;
    enable_from_if = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    mispredict = 1'b1;
    enable_from_if = 1'b0;
    @(posedge clk); #1;
    mispredict = 1'b0;
    if_req(32'h40, 32'h00C5_8593, 6);

    // Mispredict during SW is ignored
    fork
      lsb_req(1'b1, 32'h300, 32'hDEAD_BEEF, 3'd4, 32'h0, 5, acc);
      begin repeat (3) @(posedge clk); #1; mispredict = 1'b1; @(posedge clk); #1; mispredict = 1'b0; end
    join
    check("sw_mp_ram", {ram[32'h303], ram[32'h302], ram[32'h301], ram[32'h300]}, 32'hDEAD_BEEF);

    // SB to IO space with the output buffer full for three edges
    io_buffer_full = 1'b1;
    fork
`ifdef MEMCTRL_IO_STALL_EN
      lsb_req(1'b1, 32'h3_0000, 32'h5C, 3'd1, 32'h0, 5, acc);
`else
      lsb_req(1'b1, 32'h3_0000, 32'h5C, 3'd1, 32'h0, 2, acc);
`endif
      begin repeat (3) @(posedge clk); #1; io_buffer_full = 1'b0; end
    join
`ifdef MEMCTRL_IO_STALL_EN
    check("io_stall_wr", 32'({wr_trace[acc], wr_trace[acc + 1], wr_trace[acc + 2], wr_trace[acc + 3]}), 32'b0001);
`else
    check("io_nostall_wr", 32'({wr_trace[acc], wr_trace[acc + 1]}), 32'b10);
`endif
    check("io_ram", 32'(ram[32'h3_0000]), 32'h5C);

    // rdy low for two edges in the middle of a LW
    fork
      lsb_req(1'b0, 32'h104, 32'h0, 3'd4, 32'h8877_6655, 8, acc);
      begin repeat (3) @(posedge clk); #1; rdy = 1'b0; repeat (2) @(posedge clk); #1; rdy = 1'b1; end
    join

    // Asynchronous reset in the middle of a SW
    read_or_write_from_lsb = 1'b1;
    addr_from_lsb = 32'h400;
    data_from_lsb = 32'h0403_0201;
    width_from_lsb = 3'd4;
    enable_from_lsb = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("midsw_wr_active", 32'(mem_wr), 32'h1);
    rst = 1'b0;
    enable_from_lsb = 1'b0;
    #1;
    check("arst_mem_wr", 32'(mem_wr), 32'h0);
    check("arst_mem_a", mem_a, 32'h0);
    check("arst_mem_dout", 32'(mem_dout), 32'h0);
    check("arst_data_lsb", data_to_lsb, 32'h0);
    check("arst_inst", inst_to_if, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("arst_ram", {ram[32'h403], ram[32'h402], ram[32'h401], ram[32'h400]}, 32'hEEEE_0201);
    if_req(32'h40, 32'h00C5_8593, 6);

    repeat (5) @(posedge clk);
    #1;
    check("lsb_queue_empty", q_lsb.size(), 32'h0);
    check("if_queue_empty", q_if.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
`default_nettype wire
